// File: rtl/step_pkg.sv
// Shared types and constants for the step_worker block: operation and state
// encodings, datapath width and default tuning constants.
package step_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        OP_ADD     = 2'd0,
        OP_MUL     = 2'd1,
        OP_SPECIAL = 2'd2,
        OP_END     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DONE  = 2'd2,
        ST_REARM = 2'd3
    } state_e;

    localparam logic [3:0] DEF_LATENCY   = 4'd1;
    localparam data_t      DEF_ADD_CONST = 8'h01;
    localparam data_t      DEF_MUL_CONST = 8'h02;
    localparam data_t      SPECIAL_MASK  = 8'h5A;

    // The multiplier consumes one constant bit per cycle, so it always needs one cycle per bit.
    localparam logic [3:0] MUL_CYCLES    = 4'd8;

    function automatic data_t bitReverse(input data_t v);
        data_t r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/step_worker_if.sv
// Controller <-> worker handshake: level start with operand, registered result
// with a one-cycle done pulse and a busy flag.
interface step_worker_if;
    import step_pkg::*;

    logic  start;
    data_t in_data;
    data_t out_data;
    logic  done;
    logic  busy;

    modport master (
        output start,
        output in_data,
        input  out_data,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  in_data,
        output out_data,
        output done,
        output busy
    );

    modport monitor (
        input start,
        input in_data,
        input out_data,
        input done,
        input busy
    );

endinterface

// File: rtl/step_worker_mul_shift_add.sv
// Iterative shift-add multiplier, one multiplier (constant) bit per step, LSB
// first; the product is truncated to the datapath width.
module mul_shift_add
    import step_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start_i,
    input  logic  step_i,
    input  data_t operand_i,
    input  data_t const_i,
    output data_t product_o,
    output logic  last_o
);

    data_t      mcand_q, mcand_d;
    data_t      mplier_q, mplier_d;
    data_t      acc_q, acc_d;
    logic [2:0] count_q, count_d;
    data_t      partial;

    // product_o already folds in the bit being consumed this cycle, so the owner
    // can capture the complete result on the same edge as the final step.
    assign partial   = mplier_q[0] ? mcand_q : '0;
    assign product_o = acc_q + partial;
    assign last_o    = (count_q == 3'(MUL_CYCLES - 4'd1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        if (start_i) begin
            mcand_d  = operand_i;
            mplier_d = const_i;
            acc_d    = '0;
            count_d  = '0;
        end else if (step_i) begin
            acc_d    = product_o;
            mcand_d  = {mcand_q[DATA_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[DATA_W-1:1]};
            count_d  = count_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/step_worker.sv
// Single-operation worker: accepts an operand on start, computes for a fixed
// number of cycles, pulses done with the result, and refuses to rerun on a held start.
module step_worker
    import step_pkg::*;
#(
    parameter logic [1:0] OP        = 2'd0,
    parameter logic [3:0] LATENCY   = DEF_LATENCY,
    parameter data_t      ADD_CONST = DEF_ADD_CONST,
    parameter data_t      MUL_CONST = DEF_MUL_CONST
) (
    input  logic         clk,
    input  logic         rst_n,
    step_worker_if.slave bus
);

    state_e     state_q, state_d;
    data_t      operand_q, operand_d;
    data_t      outData_q, outData_d;
    logic [3:0] cnt_q, cnt_d;

    logic  accept;
    logic  calcLast;
    logic  mulStep;
    logic  mulLast;
    data_t mulProduct;
    data_t result;

    assign accept  = (state_q == ST_IDLE) && bus.start;
    assign mulStep = (state_q == ST_CALC);

    // The multiplier takes the operand straight from the bus on the accept edge,
    // in step with the operand register.
    mul_shift_add u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept),
        .step_i    (mulStep),
        .operand_i (bus.in_data),
        .const_i   (MUL_CONST),
        .product_o (mulProduct),
        .last_o    (mulLast)
    );

    always_comb begin
        result = '0;
        case (op_e'(OP))
            OP_ADD:     result = operand_q + ADD_CONST;
            OP_MUL:     result = mulProduct;
            OP_SPECIAL: result = bitReverse(operand_q) ^ SPECIAL_MASK;
            default:    result = ~operand_q;
        endcase
    end

    // Multiply length is set by its bit count, everything else by LATENCY.
    assign calcLast = (op_e'(OP) == OP_MUL) ? mulLast : (cnt_q == (LATENCY - 4'd1));

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        outData_d = outData_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    operand_d = bus.in_data;
                    cnt_d     = '0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (calcLast) begin
                    outData_d = result;
                    cnt_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = bus.start ? ST_REARM : ST_IDLE;
            end
            ST_REARM: begin
                if (!bus.start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            operand_q <= '0;
            outData_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            outData_q <= outData_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.out_data = outData_q;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: doc/step_worker.md
STEP_WORKER -- requirements
Module: step_worker

Interface
REQ-001 Parameter OP, 2'd0, operation select: 0 add, 1 mul, 2 special, 3 end.
REQ-002 Parameter LATENCY, 4'd1, CALC cycles for add/special/end; legal range 1..15.
REQ-003 Parameter ADD_CONST, 8'h01, addend for OP=add.
REQ-004 Parameter MUL_CONST, 8'h02, multiplier for OP=mul.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  level request from controller; may stay high after done.
REQ-008 in_data  input  8  operand, sampled only on accept.
REQ-009 out_data  output  8  result, registered, held until next result.
REQ-010 done  output  1  one-cycle completion pulse, coincident with valid out_data.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, CALC, DONE, REARM.
REQ-013 IDLE: start=1 at an edge SHALL capture in_data into operand register, enter CALC (accept edge = cycle 0).
REQ-014 CALC: add/special/end SHALL stay LATENCY cycles; mul SHALL stay exactly 8 cycles regardless of LATENCY.
REQ-015 CALC->DONE: out_data SHALL load the result and done SHALL be 1 for exactly that DONE cycle; done at cycle LATENCY+1 (mul: 9).
REQ-016 DONE->REARM if start=1 at that edge; DONE->IDLE if start=0.
REQ-017 REARM->IDLE only when start=0 is sampled; a held start SHALL never trigger a second operation.
REQ-018 start in CALC/DONE/REARM SHALL be ignored; in_data changes after accept SHALL not affect the result.
REQ-019 add: (operand + ADD_CONST) mod 256, carry discarded.
REQ-020 mul: low 8 bits of operand * MUL_CONST via iterative shift-add, one multiplier bit per CALC cycle, LSB first.
REQ-021 special: bit-reverse(operand) XOR 8'h5A.
REQ-022 end: bitwise inversion of operand.
REQ-023 out_data SHALL change only on the CALC->DONE edge; done SHALL be 0 in all other states.
REQ-024 Earliest new accept: one cycle after start is observed low following DONE.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, out_data=8'h00, done=0, busy=0, operand and counters cleared.
REQ-026 Reset mid-CALC SHALL abort without a done pulse; start=1 on the first post-reset edge SHALL be accepted normally.

Structure
REQ-027 Shared package step_pkg SHALL hold OP encodings, state encodings, data width (8) and default constants.
REQ-028 One sub-module mul_shift_add SHALL implement the iterative multiplier (start, operand, constant, product, 8-cycle count); other ops inline.
REQ-029 Single always-block state register plus separate next-state logic; no latches, no combinational path from start to done.

Verification
REQ-030 OP=add, ADD_CONST=03, LATENCY=2: start=1 at cycle 0, in_data=10 -> done=1 only at cycle 3, out_data=13; busy 1 cycles 1..3.
REQ-031 OP=mul, MUL_CONST=03, in_data=60 -> done at cycle 9, out_data=20 (overflow truncated).
REQ-032 OP=special, in_data=01 -> out_data=DA; OP=end, in_data=A5 -> out_data=5A.
REQ-033 start held high 20 cycles, in_data changed to FF at cycle 1 -> exactly one done pulse, result from original operand; REARM until start drops; next accept one cycle after start low.
REQ-034 rst_n=0 at cycle 2 of an 8-cycle mul -> no done, out_data=00, busy=0; new start at next edge completes correctly.
